// File: rtl/ext_port_if.sv
// ext_port_if: requester handshake and external pin bundle for the shared 4-bit output port
interface ext_port_if #(
  parameter int CNT_W = 4
);
  logic             req1;
  logic             req2;
  logic [CNT_W-1:0] len1;
  logic [CNT_W-1:0] len2;
  logic [3:0]       din1;
  logic [3:0]       din2;
  logic             rd1;
  logic             rd2;
  logic             done1;
  logic             done2;
  logic             busy;
  logic [3:0]       Dout;
  logic             ext1_clk;
  logic             ext2_clk;
  modport master (
    input  req1, req2, len1, len2, din1, din2,
    output rd1, rd2, done1, done2, busy, Dout, ext1_clk, ext2_clk
  );
  modport slave (
    output req1, req2, len1, len2, din1, din2,
    input  rd1, rd2, done1, done2, busy, Dout, ext1_clk, ext2_clk
  );
endinterface

// File: rtl/ext_port_arbiter.sv
// ext_port_arbiter: grants the shared port to one requester per burst and forwards a CLK/2 clock
// only to the granted device; every pin is driven straight from a flop.
module ext_port_arbiter #(
  parameter int MAX_BURST = 8,
  parameter int CNT_W     = 4
) (
  input logic        CLK,
  input logic        RSTn,
  ext_port_if.master bus
);
  typedef enum logic [1:0] {IDLE, XFER_L, XFER_H, GAP} state_t;
  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_BURST);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, len_g, len_eff;
  logic             grant_q, grant_d, last_q, last_d, pick;
  logic [3:0]       dout_q, dout_d;
  logic             clk1_q, clk1_d, clk2_q, clk2_d;
  logic             rd1_q, rd1_d, rd2_q, rd2_d;
  logic             done1_q, done1_d, done2_q, done2_d;
  logic             busy_q, busy_d;
  // grant/last encoding: 0 = requester 1, 1 = requester 2
  always_comb begin
    pick    = (bus.req1 & bus.req2) ? ~last_q : bus.req2;
    len_g   = pick ? bus.len2 : bus.len1;
    len_eff = (len_g == '0) ? CNT_W'(1) : (len_g > MAX_LEN) ? MAX_LEN : len_g;
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    last_d  = last_q;
    dout_d  = dout_q;
    clk1_d  = 1'b0;
    clk2_d  = 1'b0;
    rd1_d   = 1'b0;
    rd2_d   = 1'b0;
    done1_d = 1'b0;
    done2_d = 1'b0;
    case (state_q)
      IDLE: if (bus.req1 | bus.req2) begin
        grant_d = pick;
        last_d  = pick;
        cnt_d   = len_eff - CNT_W'(1);
        dout_d  = pick ? bus.din2 : bus.din1;
        rd1_d   = ~pick;
        rd2_d   = pick;
        state_d = XFER_L;
      end
      XFER_L: begin
        clk1_d  = ~grant_q;
        clk2_d  = grant_q;
        state_d = XFER_H;
      end
      XFER_H: if (cnt_q != '0) begin
        dout_d  = grant_q ? bus.din2 : bus.din1;
        rd1_d   = ~grant_q;
        rd2_d   = grant_q;
        cnt_d   = cnt_q - CNT_W'(1);
        state_d = XFER_L;
      end else begin
        done1_d = ~grant_q;
        done2_d = grant_q;
        state_d = GAP;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      dout_q  <= '0;
      clk1_q  <= 1'b0;
      clk2_q  <= 1'b0;
      rd1_q   <= 1'b0;
      rd2_q   <= 1'b0;
      done1_q <= 1'b0;
      done2_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      dout_q  <= dout_d;
      clk1_q  <= clk1_d;
      clk2_q  <= clk2_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      done1_q <= done1_d;
      done2_q <= done2_d;
      busy_q  <= busy_d;
    end
  end
  assign bus.Dout     = dout_q;
  assign bus.ext1_clk = clk1_q;
  assign bus.ext2_clk = clk2_q;
  assign bus.rd1      = rd1_q;
  assign bus.rd2      = rd2_q;
  assign bus.done1    = done1_q;
  assign bus.done2    = done2_q;
  assign bus.busy     = busy_q;
endmodule
